// File: rtl/vec_lut_pkg.sv
// Shared types, default sizes and element field helpers for the vector LUT sequencer.
package vec_lut_pkg;

    localparam int unsigned DefLanes    = 8;
    localparam int unsigned DefInw      = 8;
    localparam int unsigned DefRomDepth = 16;
    localparam int unsigned DefWordSize = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // ROM index lives in the top addrw bits of an inw-bit element.
    function automatic int unsigned lut_index(logic [31:0] elem, int unsigned inw,
                                              int unsigned addrw);
        logic [31:0] sh;
        sh = elem >> (inw - addrw);
        return sh & ((32'd1 << addrw) - 32'd1);
    endfunction

    function automatic int unsigned lut_frac(logic [31:0] elem, int unsigned fracw);
        return elem & ((32'd1 << fracw) - 32'd1);
    endfunction

endpackage

// File: rtl/vec_lut_seq_if.sv
// Input vector, ROM port and result vector handshakes of the LUT sequencer.
interface vec_lut_seq_if
    import vec_lut_pkg::*;
#(
    parameter int unsigned LANES    = DefLanes,
    parameter int unsigned INW      = DefInw,
    parameter int unsigned ROMDEPTH = DefRomDepth,
    parameter int unsigned WORDSIZE = DefWordSize
);
    localparam int unsigned ADDRW = $clog2(ROMDEPTH);

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*INW-1:0]      in_vec;
    logic [ADDRW-1:0]          rom_addr;
    logic [WORDSIZE-1:0]       rom_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*WORDSIZE-1:0] out_vec;
    logic                      busy;

    modport slave (
        input  in_valid, in_vec, rom_data, out_ready,
        output in_ready, rom_addr, out_valid, out_vec, busy
    );

    modport master (
        output in_valid, in_vec, rom_data, out_ready,
        input  in_ready, rom_addr, out_valid, out_vec, busy
    );

endinterface

// File: rtl/lut_interp_lane.sv
// Combinational linear interpolation a + ((b-a)*frac >>> FRACW); used only with LUT_INTERP_EN.
module lut_interp_lane #(
    parameter int unsigned WORDSIZE = 16,
    parameter int unsigned FRACW    = 4
) (
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic [FRACW-1:0]    frac,
    output logic [WORDSIZE-1:0] result
);
    localparam int unsigned PW = WORDSIZE + 1 + FRACW;

    logic signed [WORDSIZE:0] diff;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     step;
    logic                     unused_step_hi;

    assign diff = $signed({1'b0, b}) - $signed({1'b0, a});
    assign prod = PW'(diff) * $signed(PW'({1'b0, frac}));
    assign step = prod >>> FRACW;

    // The step never leaves [a, b], so modulo-2^WORDSIZE addition is exact.
    assign result         = a + WORDSIZE'(step);
    assign unused_step_hi = ^step[PW-1:WORDSIZE];

endmodule

// File: rtl/vec_lut_seq.sv
// Serial ROM lookup sequencer: one vector in, one ROM read per lane, assembled vector out.
// Define LUT_INTERP_EN for two reads per lane and linear interpolation on the fraction bits.
module vec_lut_seq
    import vec_lut_pkg::*;
#(
    parameter int unsigned LANES    = DefLanes,
    parameter int unsigned INW      = DefInw,
    parameter int unsigned ROMDEPTH = DefRomDepth,
    parameter int unsigned WORDSIZE = DefWordSize
) (
    input logic          CLK,
    input logic          RST,
    vec_lut_seq_if.slave bus
);
    localparam int unsigned ADDRW = $clog2(ROMDEPTH);
    localparam int unsigned FRACW = INW - ADDRW;
`ifdef LUT_INTERP_EN
    localparam int unsigned NREADS = 2 * LANES;
`else
    localparam int unsigned NREADS = LANES;
`endif
    localparam int unsigned SHIFT = (NREADS / LANES) - 1;
    localparam int unsigned CNTW  = $clog2(NREADS + 1);
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNTW-1:0]  LastRead = CNTW'(NREADS - 1);
    localparam logic [ADDRW-1:0] TopIdx   = ADDRW'(ROMDEPTH - 1);

    state_e                         state_q, state_d;
    logic [LANES-1:0][INW-1:0]      vec_q;
    logic [LANES-1:0][WORDSIZE-1:0] res_q;
    logic [CNTW-1:0]                issue_q;
    logic [CNTW-1:0]                cap_q;
    logic                           accept;
    logic                           cap_en;
    logic [LW-1:0]                  issue_lane;
    logic [LW-1:0]                  cap_lane;
    logic [ADDRW-1:0]               issue_idx;
    logic [WORDSIZE-1:0]            cap_word;

`ifdef LUT_INTERP_EN
    logic [WORDSIZE-1:0] a_q;
    logic [WORDSIZE-1:0] interp_res;
    logic [FRACW-1:0]    cap_frac;

    assign cap_frac = FRACW'(lut_frac(32'(vec_q[cap_lane]), FRACW));

    lut_interp_lane #(
        .WORDSIZE (WORDSIZE),
        .FRACW    (FRACW)
    ) u_interp (
        .a      (a_q),
        .b      (bus.rom_data),
        .frac   (cap_frac),
        .result (interp_res)
    );

    assign cap_word = interp_res;
`else
    assign cap_word = bus.rom_data;
`endif

    assign bus.in_ready  = (state_q == StIdle) & ~RST;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_vec   = res_q;

    assign accept   = bus.in_valid & bus.in_ready;
    // Reads lag their issue by one cycle; DRAIN picks up the last word.
    assign cap_en   = ((state_q == StIssue) && (issue_q != '0)) || (state_q == StDrain);
    assign cap_lane = LW'(cap_q >> SHIFT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: if (issue_q == LastRead) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue_lane = LW'(issue_q >> SHIFT);
        issue_idx  = ADDRW'(lut_index(32'(vec_q[issue_lane]), INW, ADDRW));
`ifdef LUT_INTERP_EN
        // Odd reads fetch the upper neighbour, saturating at the last entry.
        if (issue_q[0] && (issue_idx != TopIdx)) begin
            issue_idx = issue_idx + ADDRW'(1);
        end
`endif
        bus.rom_addr = '0;
        if (state_q == StIssue) begin
            bus.rom_addr = issue_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vec_q   <= '0;
            res_q   <= '0;
            issue_q <= '0;
            cap_q   <= '0;
`ifdef LUT_INTERP_EN
            a_q     <= '0;
`endif
        end else begin
            if (accept) begin
                vec_q   <= bus.in_vec;
                issue_q <= '0;
                cap_q   <= '0;
            end
            if (state_q == StIssue) begin
                issue_q <= issue_q + CNTW'(1);
            end
            if (cap_en) begin
                cap_q <= cap_q + CNTW'(1);
`ifdef LUT_INTERP_EN
                if (!cap_q[0]) begin
                    a_q <= bus.rom_data;
                end else begin
                    res_q[cap_lane] <= cap_word;
                end
`else
                res_q[cap_lane] <= cap_word;
`endif
            end
        end
    end

endmodule
